mrp_timeout_sched: RTL
======================

MRP_TIMEOUT_SCHED -- requirements
Module: mrp_timeout_sched

Interface
REQ-001 SHALL have parameter NUM_CONNS, default 16: number of MRP connection slots.
REQ-002 SHALL have parameter CONN_ID_W, default $clog2(NUM_CONNS): connection id width.
REQ-003 SHALL have parameter TICK_CYCLES, default 1024: clocks per aging tick.
REQ-004 SHALL have parameter AGE_W, default 8: per-slot age counter width.
REQ-005 SHALL have parameter TIMEOUT_AGE, default 200: age at which a slot expires; 1 <= TIMEOUT_AGE <= 2^AGE_W-1.
REQ-006 SHALL have port clk  input  1  sole clock.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-008 SHALL have ports set_timer_val  input  1 and set_timer_conn_id  input  CONN_ID_W: arm or refresh the slot.
REQ-009 SHALL have ports clear_timer_val  input  1 and clear_timer_conn_id  input  CONN_ID_W: disarm the slot.
REQ-010 SHALL have port timeout_ctrl_val  output  1  expiry request to the rx controller.
REQ-011 SHALL have port timeout_ctrl_conn_id  output  CONN_ID_W  expired slot id; valid while timeout_ctrl_val=1.
REQ-012 SHALL have port ctrl_timeout_rdy  input  1  rx controller accepts expiry.
REQ-013 SHALL have port timeouts_cnt  output  32  completed expiries.

Function
REQ-014 SHALL hold per slot an armed bit and an AGE_W-bit age.
REQ-015 SHALL, on set, write armed=1 and age=0 at the next edge.
REQ-016 SHALL, on clear, write armed=0 at the next edge; clear SHALL win over set on the same id in the same cycle.
REQ-017 SHALL raise a 1-cycle tick every TICK_CYCLES clocks, latch it as tick_pend, and drop any tick arriving while tick_pend=1.
REQ-018 SHALL use FSM IDLE, SCAN, EXPIRE; reset state IDLE.
REQ-019 IDLE: when tick_pend=1, clear tick_pend, set scan_ptr=0, go SCAN.
REQ-020 SCAN: visit slot scan_ptr once per cycle; if armed, age saturates at 2^AGE_W-1 on increment; if the new age >= TIMEOUT_AGE, go EXPIRE holding scan_ptr; else advance scan_ptr; after slot NUM_CONNS-1, go IDLE.
REQ-021 A set or clear to the slot being visited in that cycle SHALL override the scan update.
REQ-022 EXPIRE: drive timeout_ctrl_val=1 and timeout_ctrl_conn_id=scan_ptr, registered and stable, no combinational path from inputs.
REQ-023 EXPIRE with ctrl_timeout_rdy=1: write armed=0, increment timeouts_cnt (wrapping at 2^32), advance scan_ptr, and return to SCAN, or to IDLE if the slot was NUM_CONNS-1.
REQ-024 EXPIRE with set or clear on the held id and rdy=0: cancel; timeout_ctrl_val=0 from the next cycle, the set/clear applies, and the scan resumes as in REQ-023 without counting.
REQ-025 Cancellation SHALL be the only request withdrawal; the rx controller issues no set/clear between sampling val and asserting rdy.
REQ-026 ctrl_timeout_rdy while timeout_ctrl_val=0 SHALL be ignored.
REQ-027 Set/clear SHALL be accepted every cycle in every state, with no backpressure.

Reset
REQ-028 On rst=0, asynchronously: all slots armed=0, age=0; state IDLE; tick counter, tick_pend and scan_ptr 0; timeout_ctrl_val=0; timeout_ctrl_conn_id=0; timeouts_cnt=0.
REQ-029 Reset mid-EXPIRE SHALL drop the request with no count.

Configuration
REQ-030 With MRP_TIMEOUT_STATS_EN defined, timeouts_cnt SHALL be implemented per REQ-023.
REQ-031 Without MRP_TIMEOUT_STATS_EN, timeouts_cnt SHALL be constant 0 and its register omitted; all other behaviour SHALL be identical.

Structure
REQ-032 The FSM state enum and default TIMEOUT_AGE and TICK_CYCLES constants SHALL live in the shared MRP defs package/header.
REQ-033 The prescaler SHALL be sub-module mrp_timeout_tick_gen (clk, rst, tick).

Verification (NUM_CONNS=4, TICK_CYCLES=8, TIMEOUT_AGE=3)
REQ-034 Set id 2, then idle -> timeout_ctrl_val=1 with id 2 during the 3rd scan; rdy=1 -> val drops next cycle, timeouts_cnt=1, slot 2 disarmed.
REQ-035 Set id 1, then refresh id 1 every 16 cycles -> no expiry within 200 cycles.
REQ-036 Set ids 0 and 3, hold rdy=0 for 20 cycles -> val and id 0 stable 20 cycles; rdy -> id 3 requested later in the same scan.
REQ-037 Expiry pending on id 1, clear id 1 with rdy=0 -> val=0 next cycle, timeouts_cnt unchanged, slot 1 disarmed.
REQ-038 Set and clear id 2 in the same cycle -> slot 2 disarmed, no expiry; set on a slot in the cycle it is scanned -> age=0.
REQ-039 Assert rst=0 during EXPIRE -> val=0 immediately, all slots disarmed, timeouts_cnt=0; repeat REQ-034 without MRP_TIMEOUT_STATS_EN -> timeouts_cnt stays 0.

Source files
------------

// File: rtl/mrp_timeout_sched_pkg.sv
// Shared MRP timeout scheduler definitions: FSM state encoding and default timing constants.
package mrp_timeout_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_EXPIRE = 2'd2
    } sched_state_t;

    localparam int DEF_TIMEOUT_AGE = 200;
    localparam int DEF_TICK_CYCLES = 1024;

endpackage

// File: rtl/mrp_timeout_sched_tick.sv
// Aging prescaler: emits a registered one-cycle tick once every TICK_CYCLES clocks.
module mrp_timeout_tick_gen
    import mrp_timeout_sched_pkg::*;
#(
    parameter int TICK_CYCLES = DEF_TICK_CYCLES
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/mrp_timeout_sched.sv
// MRP connection timeout scheduler: ages armed slots on each tick and hands expiries to the rx controller.
// Optional expiry counter enabled by defining MRP_TIMEOUT_STATS_EN.
module mrp_timeout_sched
    import mrp_timeout_sched_pkg::*;
#(
    parameter int NUM_CONNS   = 16,
    parameter int CONN_ID_W   = $clog2(NUM_CONNS),
    parameter int TICK_CYCLES = DEF_TICK_CYCLES,
    parameter int AGE_W       = 8,
    parameter int TIMEOUT_AGE = DEF_TIMEOUT_AGE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_timer_val,
    input  logic [CONN_ID_W-1:0] set_timer_conn_id,
    input  logic                 clear_timer_val,
    input  logic [CONN_ID_W-1:0] clear_timer_conn_id,
    output logic                 timeout_ctrl_val,
    output logic [CONN_ID_W-1:0] timeout_ctrl_conn_id,
    input  logic                 ctrl_timeout_rdy,
    output logic [31:0]          timeouts_cnt
);

    localparam logic [CONN_ID_W-1:0] LAST_ID   = CONN_ID_W'(NUM_CONNS - 1);
    localparam logic [AGE_W-1:0]     TIMEOUT_V = AGE_W'(TIMEOUT_AGE);

    function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
        return (a == {AGE_W{1'b1}}) ? a : a + 1'b1;
    endfunction

    sched_state_t         state;
    logic [CONN_ID_W-1:0] scan_ptr;
    logic                 tick;
    logic                 tick_pend;
    logic [NUM_CONNS-1:0] armed;
    logic [AGE_W-1:0]     age [NUM_CONNS];

    logic             set_hit;
    logic             clr_hit;
    logic             touch_ptr;
    logic [AGE_W-1:0] next_age;
    logic             age_up;
    logic             hit_expire;
    logic             accept;
    logic             cancel;
    logic             last_slot;

    mrp_timeout_tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // A set/clear aimed at the slot under the pointer overrides aging and cancels a pending expiry.
    assign set_hit    = set_timer_val && (set_timer_conn_id == scan_ptr);
    assign clr_hit    = clear_timer_val && (clear_timer_conn_id == scan_ptr);
    assign touch_ptr  = set_hit || clr_hit;
    assign next_age   = sat_inc(age[scan_ptr]);
    assign age_up     = (state == ST_SCAN) && armed[scan_ptr] && !touch_ptr;
    assign hit_expire = age_up && (next_age >= TIMEOUT_V);
    assign accept     = (state == ST_EXPIRE) && ctrl_timeout_rdy;
    assign cancel     = (state == ST_EXPIRE) && !ctrl_timeout_rdy && touch_ptr;
    assign last_slot  = (scan_ptr == LAST_ID);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed <= '0;
            for (int i = 0; i < NUM_CONNS; i++) begin
                age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CONNS; i++) begin
                if (clear_timer_val && (clear_timer_conn_id == CONN_ID_W'(i))) begin
                    armed[i] <= 1'b0;
                end else if (set_timer_val && (set_timer_conn_id == CONN_ID_W'(i))) begin
                    armed[i] <= 1'b1;
                    age[i]   <= '0;
                end else if (age_up && (scan_ptr == CONN_ID_W'(i))) begin
                    age[i] <= next_age;
                end else if (accept && (scan_ptr == CONN_ID_W'(i))) begin
                    armed[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= ST_IDLE;
            scan_ptr             <= '0;
            tick_pend            <= 1'b0;
            timeout_ctrl_val     <= 1'b0;
            timeout_ctrl_conn_id <= '0;
        end else begin
            // Only one tick is remembered; extras arriving while one is pending are dropped.
            if (tick_pend) begin
                if (state == ST_IDLE) tick_pend <= 1'b0;
            end else if (tick) begin
                tick_pend <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (tick_pend) begin
                        scan_ptr <= '0;
                        state    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (hit_expire) begin
                        state                <= ST_EXPIRE;
                        timeout_ctrl_val     <= 1'b1;
                        timeout_ctrl_conn_id <= scan_ptr;
                    end else if (last_slot) begin
                        state <= ST_IDLE;
                    end else begin
                        scan_ptr <= scan_ptr + 1'b1;
                    end
                end
                ST_EXPIRE: begin
                    if (accept || cancel) begin
                        timeout_ctrl_val <= 1'b0;
                        if (last_slot) begin
                            state <= ST_IDLE;
                        end else begin
                            scan_ptr <= scan_ptr + 1'b1;
                            state    <= ST_SCAN;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MRP_TIMEOUT_STATS_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign timeouts_cnt = cnt_q;
`else
    assign timeouts_cnt = '0;
`endif

endmodule
